nibble_serial_adder: RTL and testbench

Multi-cycle, area-reduced wide adder. It computes WIDTH-bit A + B + cin one 4-bit nibble per clock through a single 4-bit carry-lookahead slice, and registers the nibble carry between cycles. It sits downstream of the operand source and upstream of result consumers. Where a full-width combinational adder is too large, this block replaces it. Operands and results move through valid/ready handshakes.

---
 rtl/nibble_serial_pkg.sv | 8 +
 rtl/nibble_cla_slice.sv | 32 +++
 rtl/nibble_serial_adder.sv | 146 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_pkg.sv
// rtl/nibble_serial_pkg.sv - shared state type and nibble width for the nibble-serial adder
package nibble_serial_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t;

endpackage

// File: rtl/nibble_cla_slice.sv
// rtl/nibble_cla_slice.sv - combinational 4-bit carry-lookahead slice, also exposing the carry into bit 3
module nibble_cla_slice
  import nibble_serial_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout,
  output logic             c3
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g/p and cin, so depth does not chain.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[NIB_W-1:0];
  assign cout = c[4];
  assign c3   = c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit A+B+cin computed one nibble per clock with valid/ready handshakes
// Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
  import nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / NIB_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  nsa_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NIB_W-1:0] slice_sum;
  logic             slice_cout, slice_c3;
  logic [WIDTH-1:0] a_shift, b_shift, sum_shift;
  logic             last_nib;

  nibble_cla_slice u_slice (
    .a    (a_q[NIB_W-1:0]),
    .b    (b_q[NIB_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  // Results enter sum_q at the MSB end so after N shifts nibble 0 sits at the LSB.
  if (WIDTH == NIB_W) begin : g_single
    assign a_shift   = '0;
    assign b_shift   = '0;
    assign sum_shift = slice_sum;
  end else begin : g_multi
    assign a_shift   = {{NIB_W{1'b0}}, a_q[WIDTH-1:NIB_W]};
    assign b_shift   = {{NIB_W{1'b0}}, b_q[WIDTH-1:NIB_W]};
    assign sum_shift = {slice_sum, sum_q[WIDTH-1:NIB_W]};
  end

  assign last_nib = (cnt_q == CNT_W'(N - 1));

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;
`else
  logic unused_slice_c3;
  assign unused_slice_c3 = slice_c3;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_shift;
        b_d     = b_shift;
        sum_d   = sum_shift;
        carry_d = slice_cout;
        if (last_nib) begin
          cout_d  = slice_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          ovf_d   = slice_c3 ^ slice_cout;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - randomized and directed checks of nibble_serial_adder against an arithmetic model
// Overflow checks are included when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return t[16:0];
  endfunction

  function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y, input logic c);
    int r;
    r = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (r > 32767) || (r < -32768);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_valid && lat < 20);
    if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = x; b = y; cin = c;
    step();
    in_valid = 1'b0;
    wait_out_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_cout_sum"}, {15'd0, cout, sum}, {15'd0, ref_add(x, y, c)});
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(x, y, c)));
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    logic [16:0] held;
    int          lat;
    int          cyc;
    int          last_acc;
    int          done_cnt;
    logic [16:0] exp_q[$];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    step();
    step();
    check("reset_handshake", {30'd0, in_ready, out_valid}, 32'b10);
    check("reset_cout_sum", {15'd0, cout, sum}, 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check("reset_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    do_op("ffff_p1", 16'hFFFF, 16'h0001, 1'b0);
    do_op("1234_4321_c", 16'h1234, 16'h4321, 1'b1);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    do_op("ovf_7fff", 16'h7FFF, 16'h0001, 1'b0);
    do_op("ovf_8000_neg", 16'h8000, 16'hFFFF, 1'b0);
`endif

    // Backpressure in DONE, with a stray operand beat that must not be taken.
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out_valid(lat);
    held = ref_add(16'h1234, 16'h4321, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
      step();
      check("bp_cout_sum", {15'd0, cout, sum}, {15'd0, held});
      check("bp_handshake", {30'd0, in_ready, out_valid}, 32'b01);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
    check("bp_not_captured", {15'd0, cout, sum}, {15'd0, held});

    // Reset during the second RUN cycle.
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrun_reset_handshake", {30'd0, in_ready, out_valid}, 32'b10);
    check("midrun_reset_cout_sum", {15'd0, cout, sum}, 32'd0);
    do_op("after_reset", 16'h0001, 16'h0001, 1'b0);

    // Back-to-back random traffic.
    in_valid = 1'b1;
    out_ready = 1'b1;
    last_acc = -1;
    done_cnt = 0;
    cyc = 0;
    while (done_cnt < 1000 && cyc < 8000) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_result", 32'd1, 32'd0);
        end else begin
          check("rand_cout_sum", {15'd0, cout, sum}, {15'd0, exp_q.pop_front()});
        end
        done_cnt++;
      end
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      if (in_ready) begin
        exp_q.push_back(ref_add(a, b, cin));
        if (last_acc >= 0) check("rand_accept_spacing", 32'(cyc - last_acc), 32'd6);
        last_acc = cyc;
      end
      step();
      cyc++;
    end
    check("rand_completed", 32'(done_cnt), 32'd1000);
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
